// File: rtl/div_sched_pkg.sv
// Shared definitions for the div_sched perspective divide scheduler:
// FSM state encodings and default geometry constants.
package div_sched_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t START_X = 3'd1;
  localparam state_t WAIT_X  = 3'd2;
  localparam state_t START_Y = 3'd3;
  localparam state_t WAIT_Y  = 3'd4;
  localparam state_t DONE    = 3'd5;

  localparam int unsigned DEF_WIDTH = 79;
  localparam int          DEF_H_MAX = 639;
  localparam int          DEF_V_MAX = 479;

endpackage

// File: rtl/div_sched_divider.sv
// Iterative restoring divider, one quotient bit per cycle, optional signed mode.
// No reset: the countdown drains from any power-up value, so o_ready always recovers.
module div_sched_divider #(
  parameter int unsigned WIDTH  = 79,
  parameter bit          SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic             o_ready
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg_q;

  logic [WIDTH-1:0] w_abs_dvd;
  logic [WIDTH-1:0] w_abs_dvs;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;

  always_comb begin
    w_abs_dvd = (SIGNED && i_dividend[WIDTH-1]) ? -i_dividend : i_dividend;
    w_abs_dvs = (SIGNED && i_divisor[WIDTH-1])  ? -i_divisor  : i_divisor;
    w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
    w_trial   = w_rem_sh - {1'b0, r_dvs};
  end

  // Dividend magnitude is shifted out of r_quo as quotient bits shift in.
  always_ff @(posedge clk) begin
    if (i_start) begin
      r_count <= CW'(WIDTH);
      r_quo   <= w_abs_dvd;
      r_rem   <= '0;
      r_dvs   <= w_abs_dvs;
      r_neg_q <= SIGNED && (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
      if (!w_trial[WIDTH]) begin
        r_rem <= w_trial[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
      end else begin
        r_rem <= w_rem_sh[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign o_quotient = r_neg_q ? -r_quo : r_quo;
  assign o_ready    = (r_count == '0);

endmodule

// File: rtl/div_sched.sv
// Per-pixel inverse-mapping divide scheduler: x then y on one shared signed divider.
// Optional DIV_SCHED_ZERO_GUARD_EN: zero-denominator jobs bypass the divider.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int          H_MAX = DEF_H_MAX,
  parameter int          V_MAX = DEF_V_MAX
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic signed [WIDTH-1:0] num_x,
  input  logic signed [WIDTH-1:0] num_y,
  input  logic signed [WIDTH-1:0] denom,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [WIDTH-1:0] inv_x,
  output logic signed [WIDTH-1:0] inv_y,
  output logic                    in_range,
  output logic                    busy
);

  localparam logic signed [WIDTH-1:0] X_LIM = WIDTH'(H_MAX);
  localparam logic signed [WIDTH-1:0] Y_LIM = WIDTH'(V_MAX);

  state_t                  r_state;
  logic [WIDTH-1:0]        r_num_x;
  logic [WIDTH-1:0]        r_num_y;
  logic [WIDTH-1:0]        r_denom;
  logic signed [WIDTH-1:0] r_inv_x;
  logic signed [WIDTH-1:0] r_inv_y;
  logic                    r_in_range;
  logic                    r_armed;

  logic                    w_accept;
  logic                    w_skip;
  logic                    w_div_start;
  logic [WIDTH-1:0]        w_div_dvd;
  logic [WIDTH-1:0]        w_div_q;
  logic                    w_div_ready;
  logic                    w_x_ok;
  logic                    w_y_ok;

`ifdef DIV_SCHED_ZERO_GUARD_EN
  assign w_skip = (r_denom == '0);
`else
  assign w_skip = 1'b0;
`endif

  always_comb begin
    w_accept    = job_valid && job_ready;
    w_div_start = ((r_state == START_X) && !w_skip) || (r_state == START_Y);
    w_div_dvd   = (r_state == START_Y) ? r_num_y : r_num_x;
    w_x_ok      = !r_inv_x[WIDTH-1] && (r_inv_x <= X_LIM);
    w_y_ok      = !w_div_q[WIDTH-1] && ($signed(w_div_q) <= Y_LIM);
  end

  div_sched_divider #(
    .WIDTH  (WIDTH),
    .SIGNED (1'b1)
  ) u_divider (
    .clk        (clk),
    .i_start    (w_div_start),
    .i_dividend (w_div_dvd),
    .i_divisor  (r_denom),
    .o_quotient (w_div_q),
    .o_ready    (w_div_ready)
  );

  // r_armed masks the ready level left over from the previous divide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_num_x    <= '0;
      r_num_y    <= '0;
      r_denom    <= '0;
      r_inv_x    <= '0;
      r_inv_y    <= '0;
      r_in_range <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_num_x <= num_x;
            r_num_y <= num_y;
            r_denom <= denom;
            r_state <= START_X;
          end
        end
        START_X: begin
          r_armed <= 1'b0;
          if (w_skip) begin
            r_inv_x    <= '0;
            r_inv_y    <= '0;
            r_in_range <= 1'b0;
            r_state    <= DONE;
          end else begin
            r_state <= WAIT_X;
          end
        end
        WAIT_X: begin
          if (!r_armed) begin
            r_armed <= 1'b1;
          end else if (w_div_ready) begin
            r_inv_x <= w_div_q;
            r_state <= START_Y;
          end
        end
        START_Y: begin
          r_armed <= 1'b0;
          r_state <= WAIT_Y;
        end
        WAIT_Y: begin
          if (!r_armed) begin
            r_armed <= 1'b1;
          end else if (w_div_ready) begin
            r_inv_y    <= w_div_q;
            r_in_range <= w_x_ok && w_y_ok;
            r_state    <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign job_ready = (r_state == IDLE) && w_div_ready;
  assign res_valid = (r_state == DONE);
  assign inv_x     = r_inv_x;
  assign inv_y     = r_inv_y;
  assign in_range  = r_in_range;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched: directed cases plus random jobs against
// an arithmetic reference (truncating division, range test, fixed latency).
module tb_div_sched;

  localparam int unsigned W     = 79;
  localparam int          L     = W + 1;
  localparam int          LAT   = 2 * L + 3;
  localparam int          H_MAX = 639;
  localparam int          V_MAX = 479;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                job_valid = 1'b0;
  logic                res_ready = 1'b0;
  logic signed [W-1:0] num_x = '0;
  logic signed [W-1:0] num_y = '0;
  logic signed [W-1:0] denom = '0;
  logic                job_ready;
  logic                res_valid;
  logic signed [W-1:0] inv_x;
  logic signed [W-1:0] inv_y;
  logic                in_range;
  logic                busy;

  int checks = 0;
  int errors = 0;
  int starts = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (dut.u_divider.i_start) starts++;

  div_sched #(.WIDTH(W), .H_MAX(H_MAX), .V_MAX(V_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .job_valid (job_valid),
    .job_ready (job_ready),
    .num_x     (num_x),
    .num_y     (num_y),
    .denom     (denom),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .inv_x     (inv_x),
    .inv_y     (inv_y),
    .in_range  (in_range),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic signed [W-1:0] obs,
                       input logic signed [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_range(input longint qx, input longint qy);
    return (qx >= 0) && (qx <= H_MAX) && (qy >= 0) && (qy <= V_MAX);
  endfunction

  // Offers a job, waits for acceptance, scrambles inputs, waits for res_valid.
  task automatic do_job(input longint nx, input longint ny, input longint d,
                        output int lat);
    int w;
    @(negedge clk);
    num_x = W'(nx); num_y = W'(ny); denom = W'(d); job_valid = 1'b1;
    w = 0;
    while (!job_ready && w < 500) begin @(negedge clk); w++; end
    check("accept_ready", job_ready, 1);
    starts = 0;
    @(negedge clk);
    job_valid = 1'b0;
    num_x = W'($urandom); num_y = W'($urandom); denom = W'($urandom);
    check("job_ready_low", job_ready, 0);
    lat = 1;
    while (!res_valid && lat < 1000) begin @(negedge clk); lat++; end
  endtask

  task automatic finish_job(input string tag, input int stall, input bit chk_vals,
                            input longint ex, input longint ey, input bit er,
                            input int exp_starts);
    for (int i = 0; i < stall; i++) begin
      check({tag, "_hold_valid"}, res_valid, 1);
      check({tag, "_hold_jready"}, job_ready, 0);
      check({tag, "_hold_starts"}, starts, exp_starts);
      if (chk_vals) begin
        check({tag, "_hold_x"}, inv_x, W'(ex));
        check({tag, "_hold_y"}, inv_y, W'(ey));
      end
      @(negedge clk);
    end
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_starts"}, starts, exp_starts);
    if (chk_vals) begin
      check({tag, "_inv_x"}, inv_x, W'(ex));
      check({tag, "_inv_y"}, inv_y, W'(ey));
      check({tag, "_in_range"}, in_range, er);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_valid_drop"}, res_valid, 0);
    check({tag, "_jready_rise"}, job_ready, 1);
  endtask

  task automatic run_div(input string tag, input longint nx, input longint ny,
                         input longint d, input int stall);
    int lat;
    longint qx, qy;
    qx = nx / d;
    qy = ny / d;
    do_job(nx, ny, d, lat);
    check({tag, "_latency"}, lat, LAT);
    finish_job(tag, stall, 1'b1, qx, qy, model_range(qx, qy), 2);
  endtask

  initial begin
    int lat;
    longint nx, ny, d;

    #1;
    check("rst_res_valid", res_valid, 0);
    check("rst_inv_x", inv_x, 0);
    check("rst_inv_y", inv_y, 0);
    check("rst_in_range", in_range, 0);
    check("rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_div("basic", 6400, 4800, 20, 0);
    run_div("neg", -100, 50, 10, 1);
    run_div("bnd_in", 639, 479, 1, 0);
    run_div("bnd_x", 640, 479, 1, 0);
    run_div("bnd_y", 639, 480, 1, 0);
    run_div("trunc", -7, 7, 2, 0);
    run_div("backpr", 6400, 4800, 20, 50);

    // Reset while the x divide is in flight.
    @(negedge clk);
    num_x = W'(1000); num_y = W'(2000); denom = W'(7); job_valid = 1'b1;
    while (!job_ready) @(negedge clk);
    @(negedge clk);
    job_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_x", inv_x, 0);
    check("mid_rst_y", inv_y, 0);
    check("mid_rst_range", in_range, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_jready", job_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_div("post_rst", 30, 60, 3, 0);

`ifdef DIV_SCHED_ZERO_GUARD_EN
    do_job(123, -45, 0, lat);
    check("zero_latency", lat, 2);
    finish_job("zero", 3, 1'b1, 0, 0, 1'b0, 0);
`else
    do_job(123, -45, 0, lat);
    check("zero_latency", lat, LAT);
    finish_job("zero", 0, 1'b0, 0, 0, 1'b0, 2);
`endif

    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        nx = longint'($urandom_range(0, 8000)) - 1000;
        ny = longint'($urandom_range(0, 6000)) - 1000;
      end else begin
        nx = longint'({$urandom(), $urandom()}) >>> 4;
        ny = longint'({$urandom(), $urandom()}) >>> 4;
      end
      d = longint'($urandom_range(1, 25));
      if ($urandom_range(0, 3) == 0) d = -d;
      run_div("rand", nx, ny, d, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
